mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch stage and the MEM stage (ld/st) of the 5-stage pipeline. Arbitrates and sequences each access through a request/ack handshake. Generates the stall signals that freeze IF or MEM while an access is outstanding. Data accesses have priority, with a starvation guard for fetch.

Parameters:
AW, 16, address width
DW, 32, data width
MAX_STREAK, 3, consecutive data grants allowed while a fetch is pending before fetch is forced
TIMEOUT, 64, cycles in BUSY without mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched word; registered, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse to fetch
dm_req  in  1  data request from ld/st; held with dm_we, dm_addr, dm_wdata until dm_ack
dm_we  in  1  1=st, 0=ld
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data; registered, valid when dm_ack=1
dm_ack  out  1  one-cycle completion pulse to MEM stage
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, any latency >= 0 cycles after mem_req rises
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  dm_req & ~dm_ack (combinational)
err  out  1  one-cycle timeout pulse, coincident with the aborted ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, if_ack, dm_ack, err=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; streak=0. Any in-flight memory access is abandoned. Requesters must re-issue.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
- IDLE -> BUSY_DM when dm_req=1 and not (if_req=1 and streak==MAX_STREAK).
- IDLE -> BUSY_IF when if_req=1 and (dm_req=0 or streak==MAX_STREAK).
- IDLE stays IDLE with no request.
- On entering BUSY_x: register mem_addr, mem_we (0 for fetch), and mem_wdata from the granted requester. Drive mem_req=1 for the whole BUSY_x state.
- BUSY_x, mem_ack=1 -> RESP_x. Capture mem_rdata into if_rdata or dm_rdata (loads and fetches only; dm_rdata is unchanged on stores). Drop mem_req.
- BUSY_x, mem_ack=0 -> stay in BUSY_x.
- RESP_x: assert x_ack=1 for exactly one cycle, then return to IDLE. Requests are not re-sampled in RESP. Minimum access = 3 cycles from request to ack, with mem_ack in the first BUSY cycle.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Clears on a data grant while if_req=0.
  - Saturates at MAX_STREAK.
- Both requests arriving in the same IDLE cycle: data wins unless streak==MAX_STREAK.
- mem_ack is ignored outside BUSY states.
- Requester inputs that change while a request is being served are ignored; operands are latched at grant.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a wait counter clears on entering BUSY_x and increments each BUSY cycle. When it reaches TIMEOUT with mem_ack still 0:
  - drop mem_req,
  - go to RESP_x,
  - load 0 into the x_rdata register,
  - pulse err together with x_ack.
  A late mem_ack is then ignored.
- Undefined: no counter; BUSY waits indefinitely; err is tied to 0 (port still present).

Test Plan:
- Fetch only: if_req=1, if_addr=0x0010, memory returns 0xDEADBEEF with mem_ack 0 cycles after mem_req -> mem_addr=0x0010, mem_we=0; if_ack pulses 3 cycles after request; if_rdata=0xDEADBEEF; stall_if=1 for 2 cycles.
- Simultaneous ld and fetch, streak=0: dm_addr=0x0200 -> data served first (mem_addr=0x0200), then fetch. dm_ack precedes if_ack by 3 cycles.
- Starvation guard: if_req held high, dm_req re-asserted every IDLE, MAX_STREAK=3 -> grant order DM, DM, DM, IF, DM. Streak returns to 0 after the IF grant.
- Store: dm_we=1, dm_addr=0x0044, dm_wdata=0x12345678, mem_ack after 5 cycles -> mem_we=1 and mem_wdata=0x12345678 held for 6 cycles; dm_rdata unchanged; single dm_ack pulse.
- Reset in BUSY_DM: rst_n low mid-access -> all outputs 0 immediately; after release, state is IDLE and a stale mem_ack produces no ack.
- With ARB_TIMEOUT_EN and TIMEOUT=8, memory never acks -> mem_req high for exactly 8 cycles; then if_ack=1, err=1, if_rdata=0. Without the macro, mem_req stays high and err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch, data and memory-side signals of the
//               shared memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          stall_if;
    logic          stall_mem;
    logic          err;

    // Arbiter side
    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_if, stall_mem, err
    );

    // Requesters and memory side
    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_if, stall_mem, err
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               the ld/st stage; data has priority with a fetch starvation
//               guard. Optional BUSY watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 3,
    parameter int TIMEOUT    = 64
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_port_arbiter_if.master  bus
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUSY_IF = 3'd1,
        S_BUSY_DM = 3'd2,
        S_RESP_IF = 3'd3,
        S_RESP_DM = 3'd4
    } state_t;

    if (MAX_STREAK < 1) begin : g_bad_streak
        $error("MAX_STREAK must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t        state_q,     state_d;
    logic [SW-1:0] streak_q,    streak_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;

    logic w_streak_max;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_if_ack;
    logic w_dm_ack;

    assign w_streak_max = (streak_q == SW'(MAX_STREAK));
    assign w_grant_dm   = bus.dm_req & ~(bus.if_req & w_streak_max);
    assign w_grant_if   = bus.if_req & (~bus.dm_req | w_streak_max);

`ifdef ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q,  err_d;
`endif

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_grant_dm) begin
                    state_d     = S_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    // Streak only grows while fetch is actually waiting
                    if (!bus.if_req)
                        streak_d = '0;
                    else if (!w_streak_max)
                        streak_d = streak_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end else if (w_grant_if) begin
                    state_d     = S_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end
            S_BUSY_IF, S_BUSY_DM: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == S_BUSY_IF) begin
                        state_d    = S_RESP_IF;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        state_d = S_RESP_DM;
                        if (!mem_we_q)
                            dm_rdata_d = bus.mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_q == WW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == S_BUSY_IF) begin
                        state_d    = S_RESP_IF;
                        if_rdata_d = '0;
                    end else begin
                        state_d    = S_RESP_DM;
                        dm_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_RESP_IF, S_RESP_DM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign w_if_ack      = (state_q == S_RESP_IF);
    assign w_dm_ack      = (state_q == S_RESP_DM);
    assign bus.if_ack    = w_if_ack;
    assign bus.dm_ack    = w_dm_ack;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall_if  = bus.if_req & ~w_if_ack;
    assign bus.stall_mem = bus.dm_req & ~w_dm_ack;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          hold;   // expected mem_req high cycles, -1 = unchecked
    } grant_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
        bit          err;
        int          cyc;    // expected ack cycle, -1 = unchecked
    } resp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mem_lat  = 0;
    bit   force_ack = 0;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    mem_port_arbiter_if #(.AW(16), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(16), .DW(32), .MAX_STREAK(3), .TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        if (a == 16'h0200) return 32'hCAFEF00D;
        return {16'hC0DE, a};
    endfunction

    // Memory model: acks mem_lat cycles after mem_req rises
    initial begin
        int mcnt;
        mcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBADBAD00;
                mcnt = 0;
            end else if (bus.mem_req) begin
                if (mcnt == mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end else begin
                    bus.mem_ack = 1'b0;
                end
                mcnt++;
            end else begin
                bus.mem_ack = 1'b0;
                mcnt = 0;
            end
        end
    end

    // Monitor: pops expected grants/responses as the DUT presents them
    initial begin
        bit     req_prev;
        int     hold;
        grant_t g;
        resp_t  r;
        req_prev = 1'b0;
        hold     = 0;
        g.hold   = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
                g.hold   = -1;
            end else begin
                if (bus.if_ack || bus.dm_ack) begin
                    if (exp_resp.size() == 0) begin
                        chk("spurious_ack", {30'd0, bus.dm_ack, bus.if_ack}, 32'd0);
                    end else begin
                        r = exp_resp.pop_front();
                        chk("ack_port_dm", 32'(bus.dm_ack), 32'(r.is_dm));
                        chk("ack_port_if", 32'(bus.if_ack), 32'(!r.is_dm));
                        chk(r.is_dm ? "dm_rdata" : "if_rdata",
                            r.is_dm ? bus.dm_rdata : bus.if_rdata, r.data);
                        chk("err_with_ack", 32'(bus.err), 32'(r.err));
                        if (r.cyc >= 0) chk("ack_cycle", cyc, r.cyc);
                    end
                end else if (bus.err) begin
                    chk("err_without_ack", 32'(bus.err), 32'd0);
                end

                if (bus.mem_req && !req_prev) begin
                    if (exp_grant.size() == 0) begin
                        chk("spurious_grant", 32'(bus.mem_req), 32'd0);
                        g.hold = -1;
                    end else begin
                        g = exp_grant.pop_front();
                        chk("grant_addr", 32'(bus.mem_addr), 32'(g.addr));
                        chk("grant_we", 32'(bus.mem_we), 32'(g.we));
                        if (g.we) chk("grant_wdata", bus.mem_wdata, g.wdata);
                    end
                    hold = 1;
                end else if (bus.mem_req) begin
                    hold++;
                    if (g.we) chk("we_held", 32'(bus.mem_we), 32'd1);
                end else if (req_prev && g.hold >= 0) begin
                    chk("mem_req_hold", hold, g.hold);
                end
                req_prev = bus.mem_req;
            end
        end
    end

    task automatic run_if(input logic [15:0] a, output int stalls);
        int n;
        stalls = 0;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.stall_if) stalls++;
            if (bus.if_ack) break;
        end
        if (n == 200) chk("if_ack_wait_expired", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic run_dm(input bit we, input logic [15:0] a, input logic [31:0] d,
                          output int stalls);
        int n;
        stalls = 0;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        bus.dm_req   = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.stall_mem) stalls++;
            if (bus.dm_ack) break;
        end
        if (n == 200) chk("dm_ack_wait_expired", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.dm_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int st_i, st_d, cnt_req, cnt_err, cnt_ack;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),  32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_if_ack",   32'(bus.if_ack),  32'd0);
        chk("rst_dm_ack",   32'(bus.dm_ack),  32'd0);
        chk("rst_err",      32'(bus.err),     32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Fetch only, zero-latency memory
        mem_lat = 0;
        exp_grant.push_back('{0, 16'h0010, 32'h0, 1});
        exp_resp.push_back('{0, 32'hDEADBEEF, 0, cyc + 2});
        run_if(16'h0010, st_i);
        chk("fetch_stall_if_cycles", st_i, 2);

        // Simultaneous load and fetch: load first, fetch 3 cycles later
        exp_grant.push_back('{0, 16'h0200, 32'h0, 1});
        exp_grant.push_back('{0, 16'h0014, 32'h0, 1});
        exp_resp.push_back('{1, 32'hCAFEF00D, 0, cyc + 2});
        exp_resp.push_back('{0, 32'hC0DE0014, 0, cyc + 5});
        fork
            run_dm(1'b0, 16'h0200, 32'h0, st_d);
            run_if(16'h0014, st_i);
        join

        // Starvation guard: DM DM DM IF DM DM DM IF
        for (int i = 0; i < 3; i++) begin
            exp_grant.push_back('{0, 16'h0100 + 16'(4 * i), 32'h0, 1});
            exp_resp.push_back('{1, {16'hC0DE, 16'h0100 + 16'(4 * i)}, 0, -1});
        end
        exp_grant.push_back('{0, 16'h0300, 32'h0, 1});
        exp_resp.push_back('{0, 32'hC0DE0300, 0, -1});
        for (int i = 3; i < 6; i++) begin
            exp_grant.push_back('{0, 16'h0100 + 16'(4 * i), 32'h0, 1});
            exp_resp.push_back('{1, {16'hC0DE, 16'h0100 + 16'(4 * i)}, 0, -1});
        end
        exp_grant.push_back('{0, 16'h0304, 32'h0, 1});
        exp_resp.push_back('{0, 32'hC0DE0304, 0, -1});
        fork
            begin
                run_if(16'h0300, st_i);
                run_if(16'h0304, st_i);
            end
            begin
                for (int i = 0; i < 6; i++)
                    run_dm(1'b0, 16'h0100 + 16'(4 * i), 32'h0, st_d);
            end
        join

        // Store with 5-cycle memory latency; dm_rdata keeps last load value
        mem_lat = 5;
        exp_grant.push_back('{1, 16'h0044, 32'h12345678, 6});
        exp_resp.push_back('{1, 32'hC0DE0114, 0, cyc + 7});
        run_dm(1'b1, 16'h0044, 32'h12345678, st_d);
        chk("store_stall_mem_cycles", st_d, 7);
        repeat (2) @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
        // Memory never acks: abort after 8 BUSY cycles
        mem_lat = 1000;
        exp_grant.push_back('{0, 16'h0080, 32'h0, 8});
        exp_resp.push_back('{0, 32'h0, 1, cyc + 9});
        run_if(16'h0080, st_i);
        mem_lat = 0;
        repeat (2) @(posedge clk); #1;
`endif

        // Reset in the middle of a load
        mem_lat = 20;
        exp_grant.push_back('{0, 16'h0050, 32'h0, -1});
        bus.dm_we = 1'b0; bus.dm_addr = 16'h0050; bus.dm_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("busy_before_reset", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("arst_dm_ack",   32'(bus.dm_ack),  32'd0);
        chk("arst_dm_rdata", bus.dm_rdata, 32'd0);
        chk("arst_if_rdata", bus.if_rdata, 32'd0);
        chk("arst_err",      32'(bus.err), 32'd0);
        bus.dm_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        force_ack = 1'b1;
        cnt_ack = 0; cnt_req = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack) cnt_ack++;
            if (bus.mem_req) cnt_req++;
        end
        force_ack = 1'b0;
        chk("stale_ack_no_response", cnt_ack, 0);
        chk("stale_ack_no_mem_req", cnt_req, 0);
        mem_lat = 0;
        @(posedge clk); #1;

`ifndef ARB_TIMEOUT_EN
        // Without the watchdog BUSY waits indefinitely
        mem_lat = 1000;
        exp_grant.push_back('{0, 16'h0080, 32'h0, -1});
        bus.if_addr = 16'h0080; bus.if_req = 1'b1;
        cnt_req = 0; cnt_err = 0; cnt_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_req) cnt_req++;
            if (bus.err) cnt_err++;
            if (bus.if_ack) cnt_ack++;
        end
        chk("nowdog_mem_req_cycles", cnt_req, 19);
        chk("nowdog_err", cnt_err, 0);
        chk("nowdog_no_ack", cnt_ack, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_lat = 0;
`endif

        repeat (3) @(posedge clk); #1;
        chk("grant_queue_drained", exp_grant.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
